// File: rtl/rv_muldiv_unit_if.sv
// rv_muldiv_unit_if: issue and writeback handshakes of the M-extension unit.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid and payload
// stable until that edge. On the issue side the unit samples in_op/in_rs1/
// in_rs2/in_rd only at the accepting edge. On the writeback side out_result/
// out_rd stay stable while out_valid is high. flush is a sideband abort that
// overrides both channels.
interface rv_muldiv_unit_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [XLEN-1:0]    in_rs1;
  logic [XLEN-1:0]    in_rs2;
  logic [RADDR_W-1:0] in_rd;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_result;
  logic [RADDR_W-1:0] out_rd;
  logic               busy;
  logic [1:0]         dbg_state;

  // Decode / writeback side
  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, busy, dbg_state
  );

  // Execution unit side
  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, busy, dbg_state
  );
endinterface

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32/64 M-extension unit (MUL, MULH, MULHSU,
// MULHU, DIV, DIVU, REM, REMU). Radix-2 shift-add multiply and restoring
// divide, one bit per cycle; divide-by-zero and signed overflow finish in a
// single cycle.
//
// Optional feature macro: MULDIV_PAIR_REUSE_EN. When defined, the quotient
// and remainder of the last completed divide are kept so that a following
// DIV/REM (or DIVU/REMU) on the same operands completes in one cycle.
//
// State is exported on bus.dbg_state (0 IDLE, 1 CALC, 2 DONE).
module rv_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  rv_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [2:0]         op_q;
  logic [2*XLEN-1:0]  acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]    opb;      // multiplicand magnitude or divisor magnitude
  logic               neg_lo;   // product sign / quotient sign
  logic               neg_hi;   // remainder sign (follows the dividend)
  logic [XLEN-1:0]    result_q;
  logic [RADDR_W-1:0] rd_q;

  // Issue-side decode
  logic            is_div_in;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            accept;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_hi;
  logic              div_borrow;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_result;
  logic              last_step;

`ifdef MULDIV_PAIR_REUSE_EN
  logic            c_valid;
  logic [XLEN-1:0] c_a;
  logic [XLEN-1:0] c_b;
  logic            c_signed;
  logic [XLEN-1:0] c_q;
  logic [XLEN-1:0] c_r;
  logic [XLEN-1:0] raw_a;
  logic [XLEN-1:0] raw_b;
  logic            cache_hit;
`endif

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.out_result = result_q;
  assign bus.out_rd     = rd_q;
  assign bus.dbg_state  = state;

  assign accept    = (state == IDLE) && bus.in_valid && !bus.flush;
  assign last_step = (count == CNT_W'(1));

  // Operand signedness, magnitudes and single-cycle special cases at issue
  always_comb begin
    is_div_in = bus.in_op[2];
    if (is_div_in) begin
      a_signed = ~bus.in_op[0];
      b_signed = ~bus.in_op[0];
    end else begin
      a_signed = (bus.in_op[1:0] != 2'b11);  // MUL, MULH, MULHSU
      b_signed = ~bus.in_op[1];              // MUL, MULH
    end
    a_neg    = a_signed & bus.in_rs1[XLEN-1];
    b_neg    = b_signed & bus.in_rs2[XLEN-1];
    a_mag    = a_neg ? -bus.in_rs1 : bus.in_rs1;
    b_mag    = b_neg ? -bus.in_rs2 : bus.in_rs2;
    div_zero = is_div_in && (bus.in_rs2 == '0);
    div_ovf  = is_div_in && !bus.in_op[0] &&
               (bus.in_rs1 == INT_MIN) && (bus.in_rs2 == '1);
  end

`ifdef MULDIV_PAIR_REUSE_EN
  // Same operand pair and signedness as the stored divide
  always_comb begin
    cache_hit = c_valid && is_div_in &&
                (bus.in_rs1 == c_a) && (bus.in_rs2 == c_b) &&
                (c_signed == ~bus.in_op[0]);
  end
`endif

  // One multiply or divide bit per cycle, plus sign fix-up and result select
  always_comb begin
    mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next   = {mul_sum, acc[XLEN-1:1]};

    div_hi     = acc[2*XLEN-1:XLEN-1];          // partial remainder shifted left by one
    div_borrow = (div_hi < {1'b0, opb});
    div_diff   = div_hi[XLEN-1:0] - opb;
    if (div_borrow) begin
      div_next = {div_hi[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_diff, acc[XLEN-2:0], 1'b1};
    end

    step_acc = op_q[2] ? div_next : mul_next;
    prod_fix = neg_lo ? -mul_next : mul_next;
    quo_fix  = neg_lo ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    rem_fix  = neg_hi ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

    case (op_q)
      3'b000:                 final_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_result = quo_fix;
      default:                final_result = rem_fix;
    endcase
  end

  // Control FSM: accept, iterate, hold result until writeback takes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= '0;
      acc      <= '0;
      opb      <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
`ifdef MULDIV_PAIR_REUSE_EN
      raw_a    <= '0;
      raw_b    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= bus.in_op;
            rd_q   <= bus.in_rd;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
`ifdef MULDIV_PAIR_REUSE_EN
            raw_a  <= bus.in_rs1;
            raw_b  <= bus.in_rs2;
`endif
            if (div_zero) begin
              result_q <= bus.in_op[1] ? bus.in_rs1 : '1;
              state    <= DONE;
            end else if (div_ovf) begin
              result_q <= bus.in_op[1] ? '0 : bus.in_rs1;
              state    <= DONE;
`ifdef MULDIV_PAIR_REUSE_EN
            end else if (cache_hit) begin
              result_q <= bus.in_op[1] ? c_r : c_q;
              state    <= DONE;
`endif
            end else begin
              count <= CNT_W'(XLEN);
              state <= CALC;
              if (is_div_in) begin
                acc <= {{XLEN{1'b0}}, a_mag};
                opb <= b_mag;
              end else begin
                acc <= {{XLEN{1'b0}}, b_mag};
                opb <= a_mag;
              end
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc <= step_acc;
            if (last_step) begin
              result_q <= final_result;
              state    <= DONE;
            end else begin
              count <= count - CNT_W'(1);
            end
          end
        end
        DONE: begin
          // flush wins over out_ready; both simply return to IDLE
          if (bus.flush || bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULDIV_PAIR_REUSE_EN
  // Stored divide pair: filled by a completed iterative divide, dropped by
  // a completed multiply or any flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid  <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_signed <= 1'b0;
      c_q      <= '0;
      c_r      <= '0;
    end else if (bus.flush) begin
      c_valid <= 1'b0;
    end else if ((state == CALC) && last_step) begin
      if (op_q[2]) begin
        c_valid  <= 1'b1;
        c_a      <= raw_a;
        c_b      <= raw_b;
        c_signed <= ~op_q[0];
        c_q      <= quo_fix;
        c_r      <= rem_fix;
      end else begin
        c_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: directed vector table plus hand-written sequences for
// stall, flush and divide-pair reuse behaviour of rv_muldiv_unit.
module tb_rv_muldiv_unit;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int LAT_N   = XLEN + 1;
  localparam int NVEC    = 18;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef struct {
    logic [2:0]         op;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    exp;
    int                 lat;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [XLEN-1:0] exp_q[$];
  vec_t vecs[NVEC];

  rv_muldiv_unit_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus();

  rv_muldiv_unit #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model for divide-pair reuse ----------------
`ifdef MULDIV_PAIR_REUSE_EN
  bit              m_ok = 1'b0;
  logic [XLEN-1:0] m_a  = '0;
  logic [XLEN-1:0] m_b  = '0;
  logic            m_s  = 1'b0;
`endif

  function automatic int model_latency(input logic [2:0] op, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b, input int base);
    int l;
    l = base;
`ifdef MULDIV_PAIR_REUSE_EN
    if (op[2] && base != 1) begin
      if (m_ok && m_a == a && m_b == b && m_s == ~op[0]) begin
        l = 1;
      end else begin
        m_ok = 1'b1; m_a = a; m_b = b; m_s = ~op[0];
      end
    end else if (!op[2]) begin
      m_ok = 1'b0;
    end
`endif
    return l;
  endfunction

  task automatic model_flush;
`ifdef MULDIV_PAIR_REUSE_EN
    m_ok = 1'b0;
`endif
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [RADDR_W-1:0] rd, input string name);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_rd    = rd;
    chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    // operands change right after the accept edge; the unit must ignore them
    bus.in_valid = 1'b0;
    bus.in_op    = 3'($urandom_range(0, 7));
    bus.in_rs1   = $urandom;
    bus.in_rs2   = $urandom;
    bus.in_rd    = RADDR_W'($urandom_range(0, 31));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 200);
  endtask

  task automatic retire;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] exp,
                        input int base_lat, input string name);
    int lat;
    int lat_req;
    lat_req = model_latency(op, a, b, base_lat);
    exp_q.push_back(exp);
    issue(op, a, b, rd, name);
    wait_valid(lat);
    chk({name, "_latency"}, 64'(lat), 64'(lat_req));
    chk({name, "_result"}, 64'(bus.out_result), 64'(exp_q.pop_front()));
    chk({name, "_rd"}, 64'(bus.out_rd), 64'(rd));
    retire;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int seen;

    errors = 0;
    checks = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, LAT_N};
    vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, LAT_N};
    vecs[2]  = '{OP_MULHU,  32'h8000_0000,  32'h8000_0000, 5'd5,  32'h4000_0000, LAT_N};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, LAT_N};
    vecs[4]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, LAT_N};
    vecs[5]  = '{OP_MUL,    32'h1234_5678,  32'h0000_0010, 5'd0,  32'h2345_6780, LAT_N};
    vecs[6]  = '{OP_DIV,    32'hFFFF_FFEC,  32'd3,         5'd8,  32'hFFFF_FFFA, LAT_N};
    vecs[7]  = '{OP_REM,    32'hFFFF_FFEC,  32'd3,         5'd9,  32'hFFFF_FFFE, LAT_N};
    vecs[8]  = '{OP_DIV,    32'd20,         32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFFA, LAT_N};
    vecs[9]  = '{OP_REM,    32'd20,         32'hFFFF_FFFD, 5'd11, 32'd2,         LAT_N};
    vecs[10] = '{OP_DIVU,   32'hFFFF_FFFF,  32'h0000_0010, 5'd12, 32'h0FFF_FFFF, LAT_N};
    vecs[11] = '{OP_REMU,   32'hFFFF_FFFF,  32'h0000_0010, 5'd13, 32'h0000_000F, LAT_N};
    vecs[12] = '{OP_DIVU,   32'd20,         32'd0,         5'd14, 32'hFFFF_FFFF, 1};
    vecs[13] = '{OP_REMU,   32'd20,         32'd0,         5'd15, 32'd20,        1};
    vecs[14] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1};
    vecs[15] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'd0,         1};
    vecs[16] = '{OP_REM,    32'hFFFF_FFEC,  32'd0,         5'd18, 32'hFFFF_FFEC, 1};
    vecs[17] = '{OP_MULH,   32'hFFFF_FFFF,  32'd2,         5'd31, 32'hFFFF_FFFF, LAT_N};

    // reset values, checked while reset is held and again after release
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),   64'd1);
    chk("rst_out_valid", 64'(bus.out_valid),  64'd0);
    chk("rst_busy",      64'(bus.busy),       64'd0);
    chk("rst_out_result",64'(bus.out_result), 64'd0);
    chk("rst_out_rd",    64'(bus.out_rd),     64'd0);
    chk("rst_state",     64'(bus.dbg_state),  64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready),  64'd1);
    chk("post_rst_valid",    64'(bus.out_valid), 64'd0);

    // directed vector table
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // writeback stall: result held for 5 cycles with out_ready low
    void'(model_latency(OP_MUL, 32'd7, 32'hFFFF_FFFD, LAT_N));
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd9, "stall");
    wait_valid(lat);
    chk("stall_latency", 64'(lat), 64'(LAT_N));
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k),    64'(bus.out_valid),  64'd1);
      chk($sformatf("stall%0d_result", k),   64'(bus.out_result), 64'hFFFF_FFEB);
      chk($sformatf("stall%0d_rd", k),       64'(bus.out_rd),     64'd9);
      chk($sformatf("stall%0d_in_ready", k), 64'(bus.in_ready),   64'd0);
      @(negedge clk);
    end
    retire;
    @(negedge clk);
    chk("stall_after_valid",    64'(bus.out_valid), 64'd0);
    chk("stall_after_in_ready", 64'(bus.in_ready),  64'd1);

    // flush in the middle of CALC: no result, back to IDLE next cycle
    issue(OP_DIV, 32'd100, 32'd7, 5'd2, "flush_calc");
    repeat (10) @(negedge clk);
    chk("flush_calc_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    model_flush();
    @(negedge clk);
    chk("flush_calc_in_ready",  64'(bus.in_ready),  64'd1);
    chk("flush_calc_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_calc_busy_low",  64'(bus.busy),      64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("flush_calc_no_result", 64'(seen), 64'd0);

    // flush in IDLE suppresses a same-cycle accept
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MUL;
    bus.in_rs1   = 32'd3;
    bus.in_rs2   = 32'd5;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    model_flush();
    @(negedge clk);
    chk("flush_idle_busy",     64'(bus.busy),     64'd0);
    chk("flush_idle_in_ready", 64'(bus.in_ready), 64'd1);

    // flush in DONE has priority over out_ready and drops the result
    issue(OP_DIVU, 32'd5, 32'd0, 5'd1, "flush_done");
    wait_valid(lat);
    chk("flush_done_latency", 64'(lat), 64'd1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    model_flush();
    @(negedge clk);
    chk("flush_done_valid",    64'(bus.out_valid), 64'd0);
    chk("flush_done_in_ready", 64'(bus.in_ready),  64'd1);

    // divide pair: DIV then REM on the same operands, a MUL in between
    run_op(OP_DIV,  32'd100, 32'd7, 5'd20, 32'd14, LAT_N, "pair_div");
    run_op(OP_REM,  32'd100, 32'd7, 5'd21, 32'd2,  LAT_N, "pair_rem");
    run_op(OP_MUL,  32'd3,   32'd4, 5'd22, 32'd12, LAT_N, "pair_mul");
    run_op(OP_REM,  32'd100, 32'd7, 5'd23, 32'd2,  LAT_N, "pair_rem2");
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd24, 32'd14, LAT_N, "pair_divu");

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
